toy_bus_arb_node_ack_rr: RTL and testbench

//  Two-input round-robin arbitration node for ToyBusAck packets on the bus network.

---
 rtl/toy_bus_pkg.sv | 20 ++
 rtl/toy_bus_rr_arb2.sv | 45 ++++
 rtl/toy_bus_arb_node_ack_rr.sv | 95 +++++++++
 tb/tb_toy_bus_arb_node_ack_rr.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/toy_bus_pkg.sv
// ToyBusAck shared definitions: field widths, packed ack payload and ack opcodes.
package toy_bus_pkg;

  localparam int DATA_W = 256;
  localparam int SB_W   = 10;
  localparam int ID_W   = 4;
  localparam int PKT_W  = 1 + DATA_W + SB_W + ID_W + ID_W;

  localparam logic ACK_OP_OK  = 1'b0;
  localparam logic ACK_OP_ERR = 1'b1;

  typedef struct packed {
    logic              opcode;
    logic [DATA_W-1:0] data;
    logic [SB_W-1:0]   sideband;
    logic [ID_W-1:0]   src_id;
    logic [ID_W-1:0]   tgt_id;
  } ack_pkt_t;

endpackage

// File: rtl/toy_bus_rr_arb2.sv
// Two-way round-robin grant with a one-bit pointer that moves away from each winner.
module toy_bus_rr_arb2
  import toy_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // Grant selection; rr_ptr only breaks ties when both sides request.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr_ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // On a handshake point at the side that did not win (~winner_idx == gnt[0]).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (adv && (gnt != 2'b00)) begin
      rr_ptr_d = gnt[0];
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/toy_bus_arb_node_ack_rr.sv
// Two-input round-robin merge node for ToyBusAck packets with a single registered
// output slot; full throughput, one cycle latency.
module toy_bus_arb_node_ack_rr
  import toy_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_vld,
  output logic              in0_rdy,
  input  logic              in0_opcode,
  input  logic [DATA_W-1:0] in0_data,
  input  logic [SB_W-1:0]   in0_sideband,
  input  logic [ID_W-1:0]   in0_src_id,
  input  logic [ID_W-1:0]   in0_tgt_id,
  input  logic              in1_vld,
  output logic              in1_rdy,
  input  logic              in1_opcode,
  input  logic [DATA_W-1:0] in1_data,
  input  logic [SB_W-1:0]   in1_sideband,
  input  logic [ID_W-1:0]   in1_src_id,
  input  logic [ID_W-1:0]   in1_tgt_id,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_opcode,
  output logic [DATA_W-1:0] out_data,
  output logic [SB_W-1:0]   out_sideband,
  output logic [ID_W-1:0]   out_src_id,
  output logic [ID_W-1:0]   out_tgt_id
);

  ack_pkt_t   in0_pkt;
  ack_pkt_t   in1_pkt;
  ack_pkt_t   out_pkt_q;
  ack_pkt_t   out_pkt_d;
  logic       out_vld_q;
  logic       out_vld_d;
  logic       slot_free;
  logic       adv;
  logic [1:0] gnt;

  assign in0_pkt = '{opcode: in0_opcode, data: in0_data, sideband: in0_sideband,
                     src_id: in0_src_id, tgt_id: in0_tgt_id};
  assign in1_pkt = '{opcode: in1_opcode, data: in1_data, sideband: in1_sideband,
                     src_id: in1_src_id, tgt_id: in1_tgt_id};

  // A held slot still frees up this cycle if downstream takes it; reset blocks all loads.
  assign slot_free = !out_vld_q || out_rdy;
  assign adv       = slot_free && !rst;
  assign in0_rdy   = adv && gnt[0];
  assign in1_rdy   = adv && gnt[1];

  toy_bus_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({in1_vld, in0_vld}),
    .adv (adv),
    .gnt (gnt)
  );

  // Output slot: load beats drain, drain clears valid but keeps the payload.
  always_comb begin
    out_vld_d = out_vld_q;
    out_pkt_d = out_pkt_q;
    if (in0_rdy) begin
      out_vld_d = 1'b1;
      out_pkt_d = in0_pkt;
    end else if (in1_rdy) begin
      out_vld_d = 1'b1;
      out_pkt_d = in1_pkt;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_pkt_q <= {PKT_W{1'b0}};
    end else begin
      out_vld_q <= out_vld_d;
      out_pkt_q <= out_pkt_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign out_opcode   = out_pkt_q.opcode;
  assign out_data     = out_pkt_q.data;
  assign out_sideband = out_pkt_q.sideband;
  assign out_src_id   = out_pkt_q.src_id;
  assign out_tgt_id   = out_pkt_q.tgt_id;

endmodule

// File: tb/tb_toy_bus_arb_node_ack_rr.sv
// Directed and randomized checks of the two-input round-robin ack merge node.
module tb_toy_bus_arb_node_ack_rr;
  import toy_bus_pkg::*;

  logic              clk;
  logic              rst;
  logic              in0_vld, in0_rdy, in1_vld, in1_rdy;
  logic              out_vld, out_rdy;
  logic              out_opcode;
  logic [DATA_W-1:0] out_data;
  logic [SB_W-1:0]   out_sideband;
  logic [ID_W-1:0]   out_src_id, out_tgt_id;
  logic [PKT_W-1:0]  out_pkt;
  ack_pkt_t          pay0, pay1, last_exp;

  int n_checks;
  int n_err;
  int seq;

  assign out_pkt = {out_opcode, out_data, out_sideband, out_src_id, out_tgt_id};

  toy_bus_arb_node_ack_rr dut (
    .clk (clk), .rst (rst),
    .in0_vld (in0_vld), .in0_rdy (in0_rdy), .in0_opcode (pay0.opcode),
    .in0_data (pay0.data), .in0_sideband (pay0.sideband),
    .in0_src_id (pay0.src_id), .in0_tgt_id (pay0.tgt_id),
    .in1_vld (in1_vld), .in1_rdy (in1_rdy), .in1_opcode (pay1.opcode),
    .in1_data (pay1.data), .in1_sideband (pay1.sideband),
    .in1_src_id (pay1.src_id), .in1_tgt_id (pay1.tgt_id),
    .out_vld (out_vld), .out_rdy (out_rdy), .out_opcode (out_opcode),
    .out_data (out_data), .out_sideband (out_sideband),
    .out_src_id (out_src_id), .out_tgt_id (out_tgt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ack_pkt_t nxt_pkt(input logic src);
    ack_pkt_t p;
    for (int i = 0; i < DATA_W / 32; i++) p.data[i*32 +: 32] = $urandom;
    p.opcode   = seq[0];
    p.sideband = SB_W'($urandom);
    p.src_id   = {3'b000, src};
    p.tgt_id   = ID_W'($urandom);
    seq++;
    return p;
  endfunction

  // Drive one cycle of inputs, check the ready pair, step past the next rising edge.
  task automatic cyc(input string tag, input logic v0, input logic v1, input logic ordy,
                     input logic e0, input logic e1);
    in0_vld = v0; in1_vld = v1; out_rdy = ordy;
    #1;
    chk({tag, "_rdy0"}, in0_rdy, e0);
    chk({tag, "_rdy1"}, in1_rdy, e1);
    @(posedge clk); #1;
  endtask

  // Expect source w to win with out_rdy=1, then check the registered output next cycle.
  task automatic xfer(input string tag, input logic v0, input logic v1, input logic w);
    ack_pkt_t exp;
    exp = w ? pay1 : pay0;
    cyc(tag, v0, v1, 1'b1, !w, w);
    chk({tag, "_vld"}, out_vld, 1'b1);
    chk({tag, "_pay"}, out_pkt, exp);
    last_exp = exp;
    if (w) pay1 = nxt_pkt(1'b1);
    else   pay0 = nxt_pkt(1'b0);
  endtask

  task automatic stall(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk({tag, "_vld"}, out_vld, 1'b1);
      chk({tag, "_pay"}, out_pkt, last_exp);
    end
  endtask

  logic     m_vld, m_rr, e0, e1, h0, h1, free;
  ack_pkt_t m_pkt;
  int       w0, w1;

  initial begin
    n_checks = 0; n_err = 0; seq = 0;
    rst = 1'b1; in0_vld = 1'b1; in1_vld = 1'b0; out_rdy = 1'b1;
    pay0 = nxt_pkt(1'b0);
    pay0.data = {{(DATA_W-8){1'b0}}, 8'hA5};
    pay0.tgt_id = 4'd1;
    pay1 = nxt_pkt(1'b1);
    last_exp = {PKT_W{1'b0}};

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_vld", out_vld, 1'b0);
      chk("rst_rdy0", in0_rdy, 1'b0);
      chk("rst_pay", out_pkt, {PKT_W{1'b0}});
    end
    rst = 1'b0;

    xfer("first", 1'b1, 1'b1, 1'b0);
    xfer("solo1", 1'b0, 1'b1, 1'b1);
    xfer("solo0a", 1'b1, 1'b0, 1'b0);
    xfer("solo0b", 1'b1, 1'b0, 1'b0);
    xfer("solo1b", 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) xfer("cont", 1'b1, 1'b1, i[0]);

    stall("bp", 4);
    xfer("bp_load", 1'b1, 1'b1, 1'b0);
    stall("fair_stall", 3);
    xfer("fair", 1'b1, 1'b1, 1'b1);

    cyc("drain", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("drain_vld", out_vld, 1'b0);
    chk("drain_pay", out_pkt, last_exp);
    cyc("idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    xfer("idle_rr", 1'b1, 1'b1, 1'b0);

    stall("pre_rst", 1);
    rst = 1'b1; in0_vld = 1'b1; in1_vld = 1'b1; out_rdy = 1'b1;
    #1;
    chk("rst_mid_rdy0", in0_rdy, 1'b0);
    chk("rst_mid_rdy1", in1_rdy, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_vld", out_vld, 1'b0);
    chk("rst_mid_pay", out_pkt, {PKT_W{1'b0}});
    rst = 1'b0;
    xfer("post_rst", 1'b1, 1'b1, 1'b0);

    // Randomized traffic against a small reference model of the slot and pointer.
    rst = 1'b1; in0_vld = 1'b0; in1_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_vld = 1'b0; m_rr = 1'b0; m_pkt = {PKT_W{1'b0}};
    h0 = 1'b0; h1 = 1'b0; w0 = 0; w1 = 0;
    for (int c = 0; c < 4000; c++) begin
      chk("rnd_vld", out_vld, m_vld);
      chk("rnd_pay", out_pkt, m_pkt);
      if (!in0_vld || h0) begin
        in0_vld = ($urandom_range(0, 1) == 1);
        pay0 = nxt_pkt(1'b0);
      end
      if (!in1_vld || h1) begin
        in1_vld = ($urandom_range(0, 1) == 1);
        pay1 = nxt_pkt(1'b1);
      end
      out_rdy = ($urandom_range(0, 1) == 1);
      #1;
      free = !m_vld || out_rdy;
      e0 = free && in0_vld && (!in1_vld || !m_rr);
      e1 = free && in1_vld && (!in0_vld || m_rr);
      chk("rnd_rdy0", in0_rdy, e0);
      chk("rnd_rdy1", in1_rdy, e1);
      h0 = e0; h1 = e1;
      if (e1 && in0_vld) w0++;
      if (e0 && in1_vld) w1++;
      if (e0) begin
        chk("rnd_fair0", (w0 <= 1), 1'b1);
        w0 = 0;
      end
      if (e1) begin
        chk("rnd_fair1", (w1 <= 1), 1'b1);
        w1 = 0;
      end
      if (e0 || e1) begin
        m_vld = 1'b1;
        m_pkt = e0 ? pay0 : pay1;
        m_rr  = e0;
      end else if (out_rdy) begin
        m_vld = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
